// File: rtl/a2bus_iomem_initiator_if.sv
// iomem bus bundle between the a2bus bridge (master) and an iomem responder (slave).
interface a2bus_iomem_initiator_if;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_rdata, iomem_ready
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_rdata, iomem_ready
  );
endinterface

// File: rtl/a2bus_iomem_initiator.sv
// Apple II slot register window that runs one iomem transaction per CMD write.
// Optional build macro: A2_IOMEM_INITIATOR_AUTOINC_EN (ADDR += 4 on every completion).
module a2bus_iomem_initiator #(
  parameter int unsigned SLOT           = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] a2_addr,
  input  logic [7:0]  a2_data,
  input  logic        a2_rw_n,
  input  logic        a2_data_in_strobe,
  output logic        a2_rd_en,
  output logic [7:0]  a2_data_out,
  a2bus_iomem_initiator_if.master iomem
);

  localparam logic [15:0] BASE = 16'(32'hC080 + SLOT * 16);
  localparam int unsigned CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [3:0]    r_wstrb;
  logic          r_done, r_tmo, r_is_rd;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_io_addr, r_io_wdata;
  logic [3:0]    r_io_wstrb;

  logic       w_in_win, w_wr, w_cmd_ok, w_busy;
  logic       w_ready_req, w_expire, w_complete;
  logic [3:0] w_off;

  assign w_off    = a2_addr[3:0];
  assign w_in_win = (a2_addr[15:4] == BASE[15:4]);
  assign w_wr     = a2_data_in_strobe & ~a2_rw_n & w_in_win;
  assign w_cmd_ok = w_wr && (w_off == 4'h9) && (r_state == S_IDLE) &&
                    ((a2_data == 8'h01) || (a2_data == 8'h02));

  // Ready beats an expiring counter in the same cycle, so expire requires !ready.
  assign w_ready_req = (r_state == S_REQ) & iomem.iomem_ready;
  assign w_expire    = (r_state == S_REQ) & ~iomem.iomem_ready & (r_cnt == LAST);
  assign w_complete  = w_ready_req | w_expire;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: accepted CMD starts a request, ready or timeout ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_ok)   w_state_nxt = S_REQ;
      S_REQ:   if (w_complete) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: the request is live for exactly the REQ state.
  always_comb begin
    w_busy            = (r_state == S_REQ);
    iomem.iomem_valid = w_busy;
    iomem.iomem_addr  = r_io_addr;
    iomem.iomem_wdata = r_io_wdata;
    iomem.iomem_wstrb = r_io_wstrb;
  end

  // Shadow ADDR/WDATA/WSTRB written by the 6502; an ADDR write beats auto-increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      if (w_wr && (w_off[3:2] == 2'b00))
        r_addr[{w_off[1:0], 3'b000} +: 8] <= a2_data;
`ifdef A2_IOMEM_INITIATOR_AUTOINC_EN
      else if (w_complete)
        r_addr <= r_addr + 32'd4;
`endif
      if (w_wr && (w_off[3:2] == 2'b01))
        r_wdata[{w_off[1:0], 3'b000} +: 8] <= a2_data;
      if (w_wr && (w_off == 4'h8))
        r_wstrb <= a2_data[3:0];
    end
  end

  // Snapshot of the staged transaction, held stable for the whole request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_io_addr  <= '0;
      r_io_wdata <= '0;
      r_io_wstrb <= '0;
      r_is_rd    <= 1'b0;
    end else if (w_cmd_ok) begin
      r_io_addr  <= r_addr;
      r_io_wdata <= r_wdata;
      r_io_wstrb <= (a2_data == 8'h01) ? 4'h0 : r_wstrb;
      r_is_rd    <= (a2_data == 8'h01);
    end
  end

  // Timeout counter: counts REQ cycles without ready, cleared at start and end.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     r_cnt <= '0;
    else if (w_cmd_ok || w_complete) r_cnt <= '0;
    else if (r_state == S_REQ)       r_cnt <= r_cnt + 1'b1;
  end

  // Status flags and read-data result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
      r_rdata <= '0;
    end else if (w_cmd_ok) begin
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
    end else if (w_ready_req) begin
      r_done <= 1'b1;
      if (r_is_rd) r_rdata <= iomem.iomem_rdata;
    end else if (w_expire) begin
      r_done  <= 1'b1;
      r_tmo   <= 1'b1;
      r_rdata <= '1;
    end
  end

  // 6502 read side: window decode and register read mux.
  always_comb begin
    a2_rd_en    = a2_rw_n & w_in_win;
    a2_data_out = '0;
    case (w_off)
      4'h0, 4'h1, 4'h2, 4'h3: a2_data_out = r_addr[{w_off[1:0], 3'b000} +: 8];
      4'h4, 4'h5, 4'h6, 4'h7: a2_data_out = r_wdata[{w_off[1:0], 3'b000} +: 8];
      4'h8:                   a2_data_out = {4'h0, r_wstrb};
      4'h9:                   a2_data_out = {5'b0, r_tmo, r_done, w_busy};
      4'hC, 4'hD, 4'hE, 4'hF: a2_data_out = r_rdata[{w_off[1:0], 3'b000} +: 8];
      default:                a2_data_out = '0;
    endcase
  end

endmodule
